// File: rtl/ifetch_resp_pkg.sv
// Shared fetch-path constants and types (formerly defines.v macros).
// Imported by the fetch responder and its interface.
package ifetch_resp_pkg;

   localparam int unsigned REG_BUS_WIDTH  = 32;
   localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;
   localparam logic [31:0] CPU_NOP_INST   = 32'h0000_0013;
   localparam int unsigned STALL_IFID     = 1;

   typedef logic [REG_BUS_WIDTH-1:0] reg_bus_t;

   typedef enum logic {
      RUN,
      HOLD
   } state_e;

   typedef struct packed {
      reg_bus_t inst;
      reg_bus_t pc;
      logic     fault;
   } fetch_t;

   // Misaligned, or beyond the 2^aw-word instruction RAM.
   function automatic logic pc_fault(input reg_bus_t pc, input int unsigned aw);
      return (pc[1:0] != 2'b00) || ((pc >> (aw + 2)) != '0);
   endfunction

endpackage

// File: rtl/ifetch_resp_if.sv
// Fetch-unit <-> fetch-responder bus: fetch request, stall/flush, loader and IF/ID outputs.
interface ifetch_resp_if #(
   parameter int unsigned ADDR_W = 12
) ();

   logic              ce_i;
   logic [31:0]       pc_i;
   logic [5:0]        stall_i;
   logic              flush_i;
   logic              wr_en_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [31:0]       wr_data_i;
   logic [31:0]       inst_o;
   logic [31:0]       inst_pc_o;
   logic              inst_valid_o;
   logic              fault_o;

   modport master (
      output ce_i, pc_i, stall_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
      input  inst_o, inst_pc_o, inst_valid_o, fault_o
   );

   modport slave (
      input  ce_i, pc_i, stall_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
      output inst_o, inst_pc_o, inst_valid_o, fault_o
   );

endinterface

// File: rtl/ifetch_resp_inst_ram.sv
// Simple dual-port synchronous instruction RAM, read-first on a same-word collision.
module inst_ram #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [31:0]       rd_data_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [31:0]       wr_data_i
);

   logic [31:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: RAM read, pending tag, one-entry skid for decode
// stalls, flush squash and the IF/ID output register.
module ifetch_resp
   import ifetch_resp_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter logic [31:0] RESET_ADDR = CPU_RESET_ADDR,
   parameter logic [31:0] NOP_INST   = CPU_NOP_INST
) (
   input logic          clk,
   input logic          rst,
   ifetch_resp_if.slave bus
);

   logic        stall;
   logic        issue;
   logic [31:0] rd_data;
   fetch_t      pend;

   state_e      state_q;
   logic        p_valid_q, p_valid_d;
   logic [31:0] p_pc_q, p_pc_d;
   logic        p_fault_q, p_fault_d;
   fetch_t      skid_q;
   logic [31:0] inst_q, pc_q;
   logic        valid_q, fault_q;

   assign stall = bus.stall_i[STALL_IFID];

   inst_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk       (clk),
      .rd_addr_i (bus.pc_i[ADDR_W+1:2]),
      .rd_data_o (rd_data),
      .wr_en_i   (bus.wr_en_i),
      .wr_addr_i (bus.wr_addr_i),
      .wr_data_i (bus.wr_data_i)
   );

   // A flush issues its target even while decode is stalled.
   always_comb begin
      issue      = bus.ce_i && (bus.flush_i || !stall);
      p_valid_d  = issue;
      p_pc_d     = issue ? bus.pc_i : p_pc_q;
      p_fault_d  = issue ? pc_fault(bus.pc_i, ADDR_W) : p_fault_q;
      pend.inst  = p_fault_q ? NOP_INST : rd_data;
      pend.pc    = p_pc_q;
      pend.fault = p_fault_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         p_valid_q <= 1'b0;
         p_pc_q    <= RESET_ADDR;
         p_fault_q <= 1'b0;
         skid_q    <= '0;
         inst_q    <= NOP_INST;
         pc_q      <= RESET_ADDR;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         p_valid_q <= p_valid_d;
         p_pc_q    <= p_pc_d;
         p_fault_q <= p_fault_d;
         if (bus.flush_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            skid_q  <= '0;
            state_q <= RUN;
         end else begin
            case (state_q)
               RUN: begin
                  if (!stall) begin
                     if (p_valid_q) begin
                        inst_q  <= pend.inst;
                        pc_q    <= pend.pc;
                        valid_q <= 1'b1;
                        fault_q <= pend.fault;
                     end else begin
                        inst_q  <= NOP_INST;
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                     end
                  end else if (p_valid_q) begin
                     skid_q  <= pend;
                     state_q <= HOLD;
                  end
               end
               HOLD: begin
                  if (!stall) begin
                     inst_q  <= skid_q.inst;
                     pc_q    <= skid_q.pc;
                     valid_q <= 1'b1;
                     fault_q <= skid_q.fault;
                     skid_q  <= '0;
                     state_q <= RUN;
                  end
               end
               default: state_q <= RUN;
            endcase
         end
      end
   end

   assign bus.inst_o       = inst_q;
   assign bus.inst_pc_o    = pc_q;
   assign bus.inst_valid_o = valid_q;
   assign bus.fault_o      = fault_q;

endmodule

// File: tb/tb_ifetch_resp.sv
// Bench for ifetch_resp: in-order delivery model of accepted fetches, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ifetch_resp;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        f;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifetch_resp_if #(.ADDR_W(12)) bus ();

   ifetch_resp #(.ADDR_W(12), .RESET_ADDR(32'h0), .NOP_INST(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Reference: accepted fetches are delivered in order, one per unstalled edge
   logic [31:0] mem_m [4096];
   item_t       q [$];
   logic [31:0] exp_inst = NOP;
   logic [31:0] exp_pc   = 32'h0;
   logic        exp_v    = 1'b0;
   logic        exp_f    = 1'b0;

   always @(posedge clk) begin
      item_t it;
      bit    acc;
      acc = bus.ce_i && (bus.flush_i || !bus.stall_i[1]);
      it.pc = bus.pc_i;
      it.f  = (bus.pc_i[1:0] != 2'b00) || (bus.pc_i[31:14] != 18'd0);
      it.inst = it.f ? NOP : mem_m[bus.pc_i[13:2]];
      if (rst) begin
         q.delete();
         exp_inst = NOP; exp_pc = 32'h0; exp_v = 1'b0; exp_f = 1'b0;
      end else begin
         if (bus.flush_i) begin
            q.delete();
            exp_inst = NOP; exp_v = 1'b0; exp_f = 1'b0;
         end else if (!bus.stall_i[1]) begin
            if (q.size() > 0) begin
               item_t h;
               h = q.pop_front();
               exp_inst = h.inst; exp_pc = h.pc; exp_v = 1'b1; exp_f = h.f;
            end else begin
               exp_inst = NOP; exp_v = 1'b0; exp_f = 1'b0;
            end
         end
         if (acc) q.push_back(it);
      end
      if (bus.wr_en_i) mem_m[bus.wr_addr_i] = bus.wr_data_i;
   end

   // Hand-computed expectations, checked by the compare process when armed.
   bit          lit_en = 1'b0;
   string       lit_name = "";
   logic [31:0] lit_inst, lit_pc;
   logic        lit_v, lit_f;

   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (bus.inst_o !== exp_inst || bus.inst_pc_o !== exp_pc ||
             bus.inst_valid_o !== exp_v || bus.fault_o !== exp_f) begin
            fails++;
            $display("FAIL model t=%0t got inst=%h pc=%h v=%b f=%b expected inst=%h pc=%h v=%b f=%b",
                     $time, bus.inst_o, bus.inst_pc_o, bus.inst_valid_o, bus.fault_o,
                     exp_inst, exp_pc, exp_v, exp_f);
         end
         if (lit_en) begin
            tests++;
            if (bus.inst_o !== lit_inst || bus.inst_pc_o !== lit_pc ||
                bus.inst_valid_o !== lit_v || bus.fault_o !== lit_f) begin
               fails++;
               $display("FAIL %s got inst=%h pc=%h v=%b f=%b expected inst=%h pc=%h v=%b f=%b",
                        lit_name, bus.inst_o, bus.inst_pc_o, bus.inst_valid_o, bus.fault_o,
                        lit_inst, lit_pc, lit_v, lit_f);
            end
         end
      end
   end

   task automatic step(input bit r, input bit ce, input logic [31:0] pc,
                       input logic [5:0] st, input bit fl, input bit we,
                       input logic [11:0] wa, input logic [31:0] wd);
      rst           = r;
      bus.ce_i      = ce;
      bus.pc_i      = pc;
      bus.stall_i   = st;
      bus.flush_i   = fl;
      bus.wr_en_i   = we;
      bus.wr_addr_i = wa;
      bus.wr_data_i = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc, input bit stl);
      step(1'b0, 1'b1, pc, stl ? 6'b000010 : 6'b0, 1'b0, 1'b0, 12'd0, 32'd0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 6'b0, 1'b0, 1'b0, 12'd0, 32'd0);
   endtask

   task automatic expect_lit(input string name, input logic [31:0] inst,
                             input logic [31:0] pc, input logic v, input logic f);
      lit_name = name; lit_inst = inst; lit_pc = pc; lit_v = v; lit_f = f;
      lit_en = 1'b1;
      @(negedge clk);
      #1;
      lit_en = 1'b0;
   endtask

   initial begin
      step(1'b1, 1'b0, 32'd0, 6'b0, 1'b0, 1'b0, 12'd0, 32'd0);
      chk_en = 1'b1;
      expect_lit("reset", NOP, 32'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 6'b0, 1'b0, 1'b0, 12'd0, 32'd0);

      // Program download: words 0..3 fixed, 4..63 random
      for (int unsigned w = 0; w < 64; w++) begin
         logic [31:0] d;
         d = (w < 4) ? 32'h11 * (w + 1) : $urandom;
         step(1'b0, 1'b0, 32'd0, 6'b0, 1'b0, 1'b1, 12'(w), d);
      end
      idle();

      // Back-to-back stream
      fetch(32'd0, 1'b0);
      fetch(32'd4, 1'b0);   expect_lit("stream0", 32'h11, 32'd0, 1'b1, 1'b0);
      fetch(32'd8, 1'b0);   expect_lit("stream1", 32'h22, 32'd4, 1'b1, 1'b0);
      fetch(32'd12, 1'b0);  expect_lit("stream2", 32'h33, 32'd8, 1'b1, 1'b0);
      idle();               expect_lit("stream3", 32'h44, 32'd12, 1'b1, 1'b0);
      idle();               expect_lit("bubble", NOP, 32'd12, 1'b0, 1'b0);

      // Three-cycle decode stall with a read in flight
      fetch(32'd0, 1'b0);
      fetch(32'd4, 1'b0);   expect_lit("pre_stall", 32'h11, 32'd0, 1'b1, 1'b0);
      fetch(32'd8, 1'b1);   expect_lit("stall_hold1", 32'h11, 32'd0, 1'b1, 1'b0);
      fetch(32'd8, 1'b1);
      fetch(32'd8, 1'b1);   expect_lit("stall_hold3", 32'h11, 32'd0, 1'b1, 1'b0);
      fetch(32'd8, 1'b0);   expect_lit("skid_out", 32'h22, 32'd4, 1'b1, 1'b0);
      idle();               expect_lit("after_skid", 32'h33, 32'd8, 1'b1, 1'b0);

      // Flush while the skid holds pc 8
      fetch(32'd8, 1'b0);
      fetch(32'd12, 1'b1);
      step(1'b0, 1'b1, 32'd12, 6'b000010, 1'b1, 1'b0, 12'd0, 32'd0);
      expect_lit("flush_bubble", NOP, 32'd8, 1'b0, 1'b0);
      idle();               expect_lit("flush_target", 32'h44, 32'd12, 1'b1, 1'b0);

      // Faulting fetches
      fetch(32'h2, 1'b0);
      fetch(32'h4000, 1'b0); expect_lit("misaligned", NOP, 32'h2, 1'b1, 1'b1);
      idle();                expect_lit("out_of_range", NOP, 32'h4000, 1'b1, 1'b1);

      // Read-first collision with the loader
      step(1'b0, 1'b1, 32'd4, 6'b0, 1'b0, 1'b1, 12'd1, 32'h55);
      fetch(32'd4, 1'b0);   expect_lit("read_first_old", 32'h22, 32'd4, 1'b1, 1'b0);
      idle();               expect_lit("read_first_new", 32'h55, 32'd4, 1'b1, 1'b0);

      // Reset while holding a skid entry
      fetch(32'd0, 1'b0);
      fetch(32'd4, 1'b1);
      step(1'b1, 1'b0, 32'd0, 6'b000010, 1'b0, 1'b0, 12'd0, 32'd0);
      expect_lit("reset_in_hold", NOP, 32'h0, 1'b0, 1'b0);
      fetch(32'd8, 1'b0);
      idle();               expect_lit("post_reset", 32'h33, 32'd8, 1'b1, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pc;
         logic [5:0]  st;
         int unsigned sel;
         pc  = {18'd0, 6'($urandom_range(0, 63)), 8'd0} >> 6;
         sel = $urandom_range(0, 19);
         if (sel == 0) pc = pc | 32'($urandom_range(1, 3));
         else if (sel == 1) pc = pc | (32'($urandom_range(1, 255)) << 14);
         st    = 6'($urandom);
         st[1] = ($urandom_range(0, 3) == 0);
         step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, pc, st,
              $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
              12'($urandom_range(0, 63)), $urandom);
      end
      idle();
      idle();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
